// File: rtl/multiplier_csa_26b_pkg.sv
// Width constants shared by the 26x26 carry-save multiplier and the memory-control
// top that feeds it from 52-bit words (upper half = a, lower half = b).
package multiplier_csa_26b_pkg;

   localparam int N      = 26;
   localparam int PW     = 2 * N;
   localparam int ADDR_W = 7;
   localparam int RA_W   = 5;
   localparam int CA_W   = 2;

   typedef logic [N-1:0]  operand_t;
   typedef logic [PW-1:0] product_t;

   // Split a memory word into multiplicand (upper half) and multiplier (lower half)
   function automatic operand_t word_hi(input product_t w);
      return w[PW-1:N];
   endfunction

   function automatic operand_t word_lo(input product_t w);
      return w[N-1:0];
   endfunction

endpackage

// File: rtl/multiplier_csa_26b_if.sv
// Operand/product bundle between the memory-control side and the multiplier.
interface multiplier_csa_26b_if
   import multiplier_csa_26b_pkg::*;
#(
   parameter int OP_W = multiplier_csa_26b_pkg::N
);

   logic [OP_W-1:0]   a;
   logic [OP_W-1:0]   b;
   logic [2*OP_W-1:0] out;

   modport master (output a, output b, input  out);
   modport slave  (input  a, input  b, output out);

endinterface

// File: rtl/multiplier_csa_26b_full_adder.sv
// One-bit full adder cell used for every position of the carry-save array.
module full_adder
(
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/multiplier_csa_26b.sv
// Unsigned N x N array multiplier: AND partial products reduced by a carry-save
// full-adder array, one carry-propagate add, then a single output register.
module multiplier_csa_26b
   import multiplier_csa_26b_pkg::*;
#(
   parameter int N = multiplier_csa_26b_pkg::N
)
(
   output logic [2*N-1:0] out,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           clk,
   input  logic           rstn
);

   localparam int PW = 2 * N;

   logic [PW-1:0] product_p0;

   // Each row keeps a redundant (sum, carry) pair; carries move one bit left
   // into the next row instead of rippling within the row.
   for (genvar r = 0; r < N; r++) begin : g_row
      logic [PW-1:0] pp;
      logic [PW-1:0] s;
      logic [PW-1:0] c;

      assign pp = PW'(a & {N{b[r]}}) << r;

      if (r == 0) begin : g_first
         assign s = pp;
         assign c = '0;
      end else begin : g_csa
         logic [PW:0] co;
         logic        unused_co_top;

         assign co[0] = 1'b0;
         for (genvar k = 0; k < PW; k++) begin : g_bit
            full_adder u_fa (
               .x    (g_row[r-1].s[k]),
               .y    (g_row[r-1].c[k]),
               .cin  (pp[k]),
               .s    (s[k]),
               .cout (co[k+1])
            );
         end
         assign c = co[PW-1:0];
         // The running sum never reaches 2**PW, so this carry is always zero.
         assign unused_co_top = co[PW];
      end
   end

   assign product_p0 = g_row[N-1].s + g_row[N-1].c;

   // ---- stage p0 -> output register ----
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out <= '0;
      end else begin
         out <= product_p0;
      end
   end

endmodule

// File: tb/tb_multiplier_csa_26b.sv
// Scoreboard bench for multiplier_csa_26b: driver queues expected products,
// monitor compares one registered output per clock.
module tb_multiplier_csa_26b;

   logic clk;
   logic rstn;

   multiplier_csa_26b_if #(.OP_W(26)) mif ();

   multiplier_csa_26b #(.N(26)) dut (
      .out  (mif.out),
      .a    (mif.a),
      .b    (mif.b),
      .clk  (clk),
      .rstn (rstn)
   );

   logic [51:0] exp_q [$];
   string       name_q [$];
   int          checks;
   int          errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [25:0] av, input logic [25:0] bv,
                        input logic rv, input logic [51:0] ev, input string nm);
      @(negedge clk);
      mif.a = av;
      mif.b = bv;
      rstn  = rv;
      exp_q.push_back(ev);
      name_q.push_back(nm);
   endtask

   function automatic logic [51:0] model(input logic [25:0] av, input logic [25:0] bv);
      return {26'd0, av} * {26'd0, bv};
   endfunction

   // Monitor: one product presented per edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            logic [51:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (mif.out !== e) begin
               errors++;
               $display("FAIL %s: out=%h expected=%h", nm, mif.out, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [25:0] ra, rb;
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      mif.a  = 'x;
      mif.b  = 'x;

      // Reset with unknown then maximum operands
      drive('x, 'x, 1'b0, 52'h0, "reset_x_operands");
      drive(26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 52'h0, "reset_edge1");
      drive(26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 52'h0, "reset_edge2");

      // Directed, hand-computed products
      drive(26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 52'hFFFFFF8000001, "max_x_max_first");
      drive(26'h0,       26'h2AAAAAA, 1'b1, 52'h0,             "zero_x_pattern");
      drive(26'h1,       26'h3FFFFFF, 1'b1, 52'h0000003FFFFFF, "identity");
      drive(26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 52'hFFFFFF8000001, "max_x_max");
      drive(26'd12345,   26'd6789,    1'b1, 52'd83810205,      "typical_12345_6789");
      drive(26'h2000000, 26'h2,       1'b1, 52'h0000004000000, "msb_x_two");
      drive(26'h3FFFFFF, 26'h0,       1'b1, 52'h0,             "max_x_zero");
      drive(26'h2000000, 26'h2000000, 1'b1, 52'h4000000000000, "msb_x_msb");
      drive(26'h1555555, 26'h3,       1'b1, 52'h0000003FFFFFF, "alt_x_three");
      drive(26'h3FFFFFF, 26'h2,       1'b1, 52'h0000007FFFFFE, "max_x_two");

      // Unchanged operands still reload after a reset edge
      drive(26'd5, 26'd7, 1'b1, 52'd35, "hold_before");
      drive(26'd5, 26'd7, 1'b0, 52'd0,  "hold_reset");
      drive(26'd5, 26'd7, 1'b1, 52'd35, "hold_resume");

      // rstn glitch between edges must not clear the product
      drive(26'd1000, 26'd1000, 1'b1, 52'd1000000, "glitch_no_effect");
      #1 rstn = 1'b0;
      #1 rstn = 1'b1;
      drive(26'd3, 26'd4, 1'b1, 52'd12, "after_glitch");

      // Back-to-back random traffic with one mid-stream reset edge
      for (int i = 0; i < 1000; i++) begin
         ra = 26'($urandom());
         rb = 26'($urandom());
         if (i == 500) begin
            drive(ra, rb, 1'b0, 52'h0, "midstream_reset");
         end else begin
            drive(ra, rb, 1'b1, model(ra, rb), (i == 501) ? "midstream_resume" : "random");
         end
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
